// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU port arbiter.
// Default GPIO addresses feed the optional LSU_ARB_GPIO_LOCK_EN lock.
package lsu_pkg;

    localparam int DTYPE_W    = 3;
    localparam int LSU_ADDR_W = 12;
    localparam int LSU_DATA_W = 32;

    localparam logic [11:0] GPIO_A_DEFAULT = 12'hEF0;
    localparam logic [11:0] GPIO_B_DEFAULT = 12'hEF4;

    typedef enum logic [DTYPE_W-1:0] {
        BYTE               = 3'd0,
        HALF_WORD          = 3'd1,
        FULL_WORD          = 3'd2,
        BYTE_UNSIGNED      = 3'd3,
        HALF_WORD_UNSIGNED = 3'd4
    } dtype_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic                  we;
        logic [DTYPE_W-1:0]    dtype;
    } lsu_req_t;

    function automatic logic dtype_ok(input logic [DTYPE_W-1:0] d);
        return d <= HALF_WORD_UNSIGNED;
    endfunction

endpackage

// File: rtl/lsu_rr_arb.sv
// Two-way round-robin grant with a last_grant register.
// last_grant resets to 1 so port 0 wins the first contention.
module lsu_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant
);

    logic last_grant;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req[0] && req[1]): grant = ~last_grant;
            (req[1] && !req[0]): grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares the LSU data port between core (port 0) and debug/DMA (port 1).
// Define LSU_ARB_GPIO_LOCK_EN to block port-1 stores to the GPIO registers.
module lsu_port_arbiter
    import lsu_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDRESS_SPACE = 4096,
    parameter logic [11:0] GPIO_A_ADDR   = GPIO_A_DEFAULT,
    parameter logic [11:0] GPIO_B_ADDR   = GPIO_B_DEFAULT,
    localparam int         ADDR_W        = $clog2(ADDRESS_SPACE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p0_we,
    input  logic [DTYPE_W-1:0]    p0_dtype,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_we,
    input  logic [DTYPE_W-1:0]    p1_dtype,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,
    output logic [ADDR_W-1:0]     lsu_addr_o,
    output logic [DATA_WIDTH-1:0] lsu_wdata_o,
    output logic                  lsu_we_o,
    output logic [DTYPE_W-1:0]    lsu_dtype_o,
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
    output logic                  busy_o
);

`ifdef LSU_ARB_GPIO_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    arb_state_e            state;
    lsu_req_t              cmd;
    logic                  cmd_owner;
    logic                  cmd_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_owner;

    logic     window;
    logic     accept;
    logic     grant;
    lsu_req_t sel;
    logic     gpio_hit;
    logic     sel_err;

    assign window = (state == IDLE) || (state == RESP);
    assign accept = window && (p0_req_valid || p1_req_valid);

    lsu_rr_arb u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({p1_req_valid, p0_req_valid}),
        .accept  (accept),
        .grant   (grant)
    );

    assign p0_req_ready = window && !grant && p0_req_valid;
    assign p1_req_ready = window && grant && p1_req_valid;

    always_comb begin
        sel = '0;
        if (grant) begin
            sel.addr  = LSU_ADDR_W'(p1_addr);
            sel.wdata = LSU_DATA_W'(p1_wdata);
            sel.we    = p1_we;
            sel.dtype = p1_dtype;
        end else begin
            sel.addr  = LSU_ADDR_W'(p0_addr);
            sel.wdata = LSU_DATA_W'(p0_wdata);
            sel.we    = p0_we;
            sel.dtype = p0_dtype;
        end
    end

    assign gpio_hit = (sel.addr == LSU_ADDR_W'(GPIO_A_ADDR))
                   || (sel.addr == LSU_ADDR_W'(GPIO_B_ADDR));

    // Errors are resolved at accept so the ISSUE cycle can suppress the write.
    assign sel_err = !dtype_ok(sel.dtype)
                  || (LOCK_EN && grant && sel.we && gpio_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_owner <= 1'b0;
            cmd_err   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            if (accept) begin
                cmd       <= sel;
                cmd_owner <= grant;
                cmd_err   <= sel_err;
            end
            unique case (state)
                IDLE:  state <= accept ? ISSUE : IDLE;
                ISSUE: state <= WAIT;
                WAIT: begin
                    state     <= RESP;
                    rsp_rdata <= (cmd.we || cmd_err) ? '0 : lsu_rdata_i;
                    rsp_err   <= cmd_err;
                    rsp_owner <= cmd_owner;
                end
                RESP:  state <= accept ? ISSUE : IDLE;
            endcase
        end
    end

    assign lsu_addr_o  = ADDR_W'(cmd.addr);
    assign lsu_wdata_o = DATA_WIDTH'(cmd.wdata);
    assign lsu_dtype_o = cmd.dtype;
    assign lsu_we_o    = (state == ISSUE) && cmd.we && !cmd_err;
    assign busy_o      = (state != IDLE);

    assign p0_rsp_valid = (state == RESP) && !rsp_owner;
    assign p1_rsp_valid = (state == RESP) && rsp_owner;
    assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata : '0;
    assign p0_rsp_err   = p0_rsp_valid && rsp_err;
    assign p1_rsp_err   = p1_rsp_valid && rsp_err;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Scoreboard bench for lsu_port_arbiter with a one-cycle-latency LSU model.
// GPIO lock expectations follow LSU_ARB_GPIO_LOCK_EN.
module tb_lsu_port_arbiter;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req_valid, p0_req_ready, p0_we;
    logic [11:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [2:0]  p0_dtype;
    logic        p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_we;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [2:0]  p1_dtype;
    logic        p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_rsp_rdata;
    logic [11:0] lsu_addr_o;
    logic [31:0] lsu_wdata_o;
    logic        lsu_we_o;
    logic [2:0]  lsu_dtype_o;
    logic [31:0] lsu_rdata_i = '0;
    logic        busy_o;

    always #5 clk = ~clk;

    lsu_port_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_we        (p0_we),
        .p0_dtype     (p0_dtype),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_we        (p1_we),
        .p1_dtype     (p1_dtype),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .lsu_addr_o   (lsu_addr_o),
        .lsu_wdata_o  (lsu_wdata_o),
        .lsu_we_o     (lsu_we_o),
        .lsu_dtype_o  (lsu_dtype_o),
        .lsu_rdata_i  (lsu_rdata_i),
        .busy_o       (busy_o)
    );

    // Byte-addressed little-endian LSU stand-in.
    logic [7:0] mem [0:4095];

    function automatic logic [31:0] lsu_rd(input logic [11:0] a,
                                           input logic [2:0] d);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 12'd1];
        b2 = mem[a + 12'd2];
        b3 = mem[a + 12'd3];
        case (d)
            3'd0: return {{24{b0[7]}}, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd2: return {b3, b2, b1, b0};
            3'd3: return {24'd0, b0};
            3'd4: return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (lsu_we_o) begin
            mem[lsu_addr_o] <= lsu_wdata_o[7:0];
            if (lsu_dtype_o == 3'd1 || lsu_dtype_o == 3'd2 || lsu_dtype_o == 3'd4)
                mem[lsu_addr_o + 12'd1] <= lsu_wdata_o[15:8];
            if (lsu_dtype_o == 3'd2) begin
                mem[lsu_addr_o + 12'd2] <= lsu_wdata_o[23:16];
                mem[lsu_addr_o + 12'd3] <= lsu_wdata_o[31:24];
            end
        end
        lsu_rdata_i <= lsu_rd(lsu_addr_o, lsu_dtype_o);
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   we_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic take(input int port);
        exp_t e;
        logic [31:0] ra;
        logic ea;
        ra = port ? p1_rsp_rdata : p0_rsp_rdata;
        ea = port ? p1_rsp_err : p0_rsp_err;
        if ((port ? q1.size() : q0.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d unexpected rsp: got rdata %h err %b expected none",
                     port, ra, ea);
        end else begin
            e = port ? q1.pop_front() : q0.pop_front();
            chk($sformatf("p%0d rsp rdata", port), ra, e.rdata);
            chk($sformatf("p%0d rsp err", port), {31'd0, ea}, {31'd0, e.err});
            chk($sformatf("p%0d rsp cycle", port), cyc, e.cyc);
        end
    endtask

    // Monitor: pops the per-port scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (reset_n) begin
            if (lsu_we_o) we_cnt++;
            if (p0_rsp_valid && p1_rsp_valid)
                chk("rsp exclusive", 32'd1, 32'd0);
            if (p0_rsp_valid) take(0);
            if (p1_rsp_valid) take(1);
        end
    end

    task automatic issue(input int port, input logic [11:0] a,
                         input logic [31:0] wd, input logic we,
                         input logic [2:0] dt, input logic [31:0] er,
                         input logic ee);
        int n;
        exp_t e;
        @(negedge clk);
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_addr = a; p0_wdata = wd;
            p0_we = we; p0_dtype = dt;
        end else begin
            p1_req_valid = 1'b1; p1_addr = a; p1_wdata = wd;
            p1_we = we; p1_dtype = dt;
        end
        #1;
        n = 0;
        while (!(port ? p1_req_ready : p0_req_ready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL p%0d accept timeout: got no ready expected ready", port);
        end else begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + 3;
            if (port == 0) q0.push_back(e);
            else q1.push_back(e);
            grant_log.push_back(port);
            @(posedge clk);
            #1;
        end
        if (port == 0) p0_req_valid = 1'b0;
        else p1_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0",
                     q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0, g0, bl;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        p0_req_valid = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0; p0_dtype = 0;
        p1_req_valid = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0; p1_dtype = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset we", {31'd0, lsu_we_o}, 32'd0);
        chk("reset addr", {20'd0, lsu_addr_o}, 32'd0);
        chk("reset wdata", lsu_wdata_o, 32'd0);
        chk("reset rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Store then load on port 0
        w0 = we_cnt;
        issue(0, 12'h010, 32'hDEADBEEF, 1'b1, FULL_WORD, 32'h0, 1'b0);
        issue(0, 12'h010, 32'h0, 1'b0, FULL_WORD, 32'hDEADBEEF, 1'b0);
        drain();
        chk("t1 we cycles", 32'(we_cnt - w0), 32'd1);

        // Simultaneous requests straight after reset
        reset_pulse();
        g0 = grant_log.size();
        fork
            issue(0, 12'h010, 32'h0, 1'b0, HALF_WORD, 32'hFFFFBEEF, 1'b0);
            issue(1, 12'h010, 32'h0, 1'b0, FULL_WORD, 32'hDEADBEEF, 1'b0);
        join
        drain();
        chk("t2 first grant", 32'(grant_log[g0]), 32'd0);
        chk("t2 second grant", 32'(grant_log[g0 + 1]), 32'd1);

        // Continuous contention: alternating grants, busy throughout
        g0 = grant_log.size();
        bl = 0;
        fork
            begin
                issue(0, 12'h010, 32'h0, 1'b0, HALF_WORD_UNSIGNED, 32'h0000BEEF, 1'b0);
                issue(0, 12'h012, 32'h0, 1'b0, HALF_WORD, 32'hFFFFDEAD, 1'b0);
                issue(0, 12'h011, 32'h0, 1'b0, BYTE_UNSIGNED, 32'h000000BE, 1'b0);
            end
            begin
                issue(1, 12'h013, 32'h0, 1'b0, BYTE, 32'hFFFFFFDE, 1'b0);
                issue(1, 12'h010, 32'h0, 1'b0, FULL_WORD, 32'hDEADBEEF, 1'b0);
                issue(1, 12'h012, 32'h0, 1'b0, BYTE_UNSIGNED, 32'h000000AD, 1'b0);
            end
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (18) begin
                    @(negedge clk);
                    if (!busy_o) bl++;
                end
            end
        join
        drain();
        chk("t3 busy low cycles", 32'(bl), 32'd0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3 grant %0d", i), 32'(grant_log[g0 + i]), 32'(i % 2));

        // Byte store and signed/unsigned loads on port 1
        issue(1, 12'h021, 32'h000000F0, 1'b1, BYTE, 32'h0, 1'b0);
        issue(1, 12'h021, 32'h0, 1'b0, BYTE, 32'hFFFFFFF0, 1'b0);
        issue(1, 12'h021, 32'h0, 1'b0, BYTE_UNSIGNED, 32'h000000F0, 1'b0);
        drain();

        // Invalid dtypes: no write, error response
        w0 = we_cnt;
        issue(0, 12'h030, 32'h12345678, 1'b1, 3'b111, 32'h0, 1'b1);
        issue(0, 12'h010, 32'h0, 1'b0, 3'b101, 32'h0, 1'b1);
        drain();
        chk("t5 we cycles", 32'(we_cnt - w0), 32'd0);
        chk("t5 mem", {mem[12'h033], mem[12'h032], mem[12'h031], mem[12'h030]}, 32'd0);

        // Reset during WAIT of a load
        issue(0, 12'h010, 32'h0, 1'b0, FULL_WORD, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst wait busy", {31'd0, busy_o}, 32'd0);
        chk("rst wait addr", {20'd0, lsu_addr_o}, 32'd0);
        chk("rst wait dtype", {29'd0, lsu_dtype_o}, 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset during ISSUE of a store: the write must not commit
        issue(0, 12'h040, 32'hCAFEF00D, 1'b1, FULL_WORD, 32'h0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst issue we", {31'd0, lsu_we_o}, 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        g0 = grant_log.size();
        fork
            issue(0, 12'h010, 32'h0, 1'b0, FULL_WORD, 32'hDEADBEEF, 1'b0);
            issue(1, 12'h040, 32'h0, 1'b0, FULL_WORD, 32'h0, 1'b0);
        join
        drain();
        chk("rst rr restart", 32'(grant_log[g0]), 32'd0);

        // GPIO register stores from each port
`ifdef LSU_ARB_GPIO_LOCK_EN
        issue(1, 12'hEF0, 32'h11111111, 1'b1, FULL_WORD, 32'h0, 1'b1);
        drain();
        chk("gpio p1 mem", {mem[12'hEF3], mem[12'hEF2], mem[12'hEF1], mem[12'hEF0]},
            32'h0);
`else
        issue(1, 12'hEF0, 32'h11111111, 1'b1, FULL_WORD, 32'h0, 1'b0);
        drain();
        chk("gpio p1 mem", {mem[12'hEF3], mem[12'hEF2], mem[12'hEF1], mem[12'hEF0]},
            32'h11111111);
`endif
        issue(0, 12'hEF0, 32'h22222222, 1'b1, FULL_WORD, 32'h0, 1'b0);
        drain();
        chk("gpio p0 mem", {mem[12'hEF3], mem[12'hEF2], mem[12'hEF1], mem[12'hEF0]},
            32'h22222222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
